// File: rtl/intf_sum_pkg.sv
// intf_sum_pkg: shared widths, result type and the width-generic adder helper.
// The optional INTF_SUM_SAT_EN macro is consumed by intf_sum_add, not here.
`default_nettype none

package intf_sum_pkg;

   localparam int unsigned N_DEFAULT = 4;
   localparam int unsigned MAX_W     = 32;

   typedef struct packed {
      logic             carry;
      logic [MAX_W-1:0] y;
   } sum_res_t;

   // Operands arrive zero-extended to MAX_W; w selects which bit is the carry.
   function automatic sum_res_t add_c(input logic [MAX_W-1:0] a,
                                      input logic [MAX_W-1:0] b,
                                      input int unsigned      w);
      logic [MAX_W:0]   s;
      logic [MAX_W-1:0] m;
      sum_res_t         r;
      s       = {1'b0, a} + {1'b0, b};
      m       = ~({MAX_W{1'b1}} << w);
      r.y     = s[MAX_W-1:0] & m;
      r.carry = ((s >> w) & (MAX_W+1)'(1)) != '0;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/intf_sum_add.sv
// intf_sum_add: combinational N+1-bit adder; with INTF_SUM_SAT_EN defined the
// sum saturates to all-ones on overflow while carry still reports bit N.
`default_nettype none

module intf_sum_add
   import intf_sum_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] y_o,
   output logic         carry_o
);

   sum_res_t     res;
   logic [N-1:0] sum_y;

   assign res     = add_c(MAX_W'(a_i), MAX_W'(b_i), N);
   assign sum_y   = res.y[N-1:0];
   assign carry_o = res.carry;

   // Bits above N are always zero after masking in add_c.
   generate
      if (N < MAX_W) begin : g_hi
         logic hi_unused;
         assign hi_unused = |res.y[MAX_W-1:N];
      end
   endgenerate

`ifdef INTF_SUM_SAT_EN
   assign y_o = res.carry ? {N{1'b1}} : sum_y;
`else
   assign y_o = sum_y;
`endif

endmodule

`default_nettype wire

// File: rtl/intf_sum.sv
// intf_sum: registered N-bit adder with valid/ready on both sides and a
// one-deep output stage. Saturating mode is selected by INTF_SUM_SAT_EN.
`default_nettype none

module intf_sum
   import intf_sum_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] y,
   output logic         carry
);

   logic         valid_q, valid_d;
   logic [N-1:0] y_q, y_d;
   logic         carry_q, carry_d;
   logic [N-1:0] add_y;
   logic         add_carry;
   logic         accept;

   intf_sum_add #(.N(N)) u_add (
      .a_i     (a),
      .b_i     (b),
      .y_o     (add_y),
      .carry_o (add_carry)
   );

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      valid_d = valid_q;
      y_d     = y_q;
      carry_d = carry_q;
      if (accept) begin
         valid_d = 1'b1;
         y_d     = add_y;
         carry_d = add_carry;
      end else if (out_ready) begin
         // Draining leaves y/carry showing the last result.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         y_q     <= '0;
         carry_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         y_q     <= y_d;
         carry_q <= carry_d;
      end
   end

   assign out_valid = valid_q;
   assign y         = y_q;
   assign carry     = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_intf_sum.sv
// tb_intf_sum: directed and randomized checks of intf_sum (N=4) against a
// queue-based reference model, plus an N=8 boundary case.
`default_nettype none

module tb_intf_sum;

`ifdef INTF_SUM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] a = '0, b = '0;
   logic       in_ready, out_valid, carry;
   logic [3:0] y;

   logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       in_ready8, out_valid8, carry8;
   logic [7:0] y8;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int unsigned y;
      bit          c;
   } res_t;

   res_t q[$];
   res_t shown;

   always #5 clk = ~clk;

   intf_sum #(.N(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .carry(carry)
   );

   intf_sum #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .y(y8), .carry(carry8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic res_t ref_sum(input int unsigned x, input int unsigned z, input int unsigned w);
      res_t        r;
      int unsigned s;
      int unsigned lim;
      s   = x + z;
      lim = 1 << w;
      r.c = (s >= lim);
      if (r.c && SAT) r.y = lim - 1;
      else            r.y = s % lim;
      return r;
   endfunction

   // Called one time unit after a rising edge; returns one unit after the next.
   task automatic step(input bit v, input int unsigned ua, input int unsigned ub, input bit rdy);
      bit   exp_rdy;
      res_t r;
      in_valid  = v;
      a         = 4'(ua);
      b         = 4'(ub);
      out_ready = rdy;
      exp_rdy   = (q.size() == 0) || rdy;
      #1;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (v && exp_rdy) begin
         r = ref_sum(ua & 15, ub & 15, 4);
         q.delete();
         q.push_back(r);
         shown = r;
      end else if (q.size() != 0 && rdy) begin
         void'(q.pop_front());
      end
      #1;
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("y", 32'(y), shown.y);
      check("carry", 32'(carry), 32'(shown.c));
   endtask

   initial begin
      shown = '{y: 0, c: 1'b0};

      #1 rst = 1'b1;
      #2;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_y", 32'(y), 0);
      check("rst_carry", 32'(carry), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1 rst = 1'b0;

      // No overflow, then wrap/saturate.
      step(1, 12, 1, 1);
      check("dir_12p1_y", 32'(y), 13);
      check("dir_12p1_c", 32'(carry), 0);
      step(1, 12, 12, 1);
      check("dir_12p12_y", 32'(y), SAT ? 15 : 8);
      check("dir_12p12_c", 32'(carry), 1);
      step(0, 0, 0, 1);

      // Back-pressure: one result held for five cycles while a/b churn.
      step(1, 5, 6, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, $urandom_range(15), $urandom_range(15), 0);
         check("bp_y_hold", 32'(y), 11);
      end
      step(0, 0, 0, 1);

      // Streaming without bubbles.
      step(1, 1, 2, 1);
      check("stream0", 32'(y), 3);
      step(1, 3, 4, 1);
      check("stream1", 32'(y), 7);
      step(1, 15, 15, 1);
      check("stream2", 32'(y), SAT ? 15 : 14);
      check("stream2_c", 32'(carry), 1);

      // Boundaries.
      step(1, 0, 0, 1);
      check("bnd_0p0_y", 32'(y), 0);
      check("bnd_0p0_c", 32'(carry), 0);
      step(1, 15, 1, 1);
      check("bnd_15p1_y", 32'(y), SAT ? 15 : 0);
      check("bnd_15p1_c", 32'(carry), 1);

      // Asynchronous reset while a result is stalled.
      step(1, 9, 9, 0);
      in_valid = 1'b0;
      rst      = 1'b1;
      #2;
      check("arst_valid", 32'(out_valid), 0);
      check("arst_y", 32'(y), 0);
      check("arst_carry", 32'(carry), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      q.delete();
      shown = '{y: 0, c: 1'b0};

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(1)), $urandom_range(15), $urandom_range(15),
              1'($urandom_range(3) != 0));
      end

      // Wider instance: 255 + 255.
      in_valid8  = 1'b1;
      a8         = 8'd255;
      b8         = 8'd255;
      out_ready8 = 1'b1;
      #1;
      check("n8_in_ready", 32'(in_ready8), 1);
      @(posedge clk);
      #1;
      check("n8_valid", 32'(out_valid8), 1);
      check("n8_y", 32'(y8), SAT ? 255 : 254);
      check("n8_carry", 32'(carry8), 1);
      in_valid8 = 1'b0;
      @(posedge clk);
      #1;
      check("n8_drain_valid", 32'(out_valid8), 0);
      check("n8_drain_y", 32'(y8), SAT ? 255 : 254);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
